// File: rtl/adc_gain_offset_calc_if.sv
`default_nettype none
// ============================================================================
// Module : adc_gain_offset_calc_if
// Brief  : Sample-in / result-out handshake bundle for adc_gain_offset_calc.
// Rev    : 1.0
// ============================================================================
interface adc_gain_offset_calc_if #(
   parameter int ADC_WIDTH = 18
);
   logic [ADC_WIDTH-1:0] i_data;
   logic [2:0]           i_ch;
   logic                 i_valid;
   logic                 o_ready;
   logic [31:0]          o_data;
   logic [2:0]           o_ch;
   logic                 o_valid;
   logic                 i_ready;

   modport slave (
      input  i_data, i_ch, i_valid, i_ready,
      output o_ready, o_data, o_ch, o_valid
   );

   modport master (
      output i_data, i_ch, i_valid, i_ready,
      input  o_ready, o_data, o_ch, o_valid
   );
endinterface
`default_nettype wire

// File: rtl/adc_gain_offset_calc.sv
`default_nettype none
// ============================================================================
// Module : adc_gain_offset_calc
// Brief  : 3-stage per-channel ADC gain/offset calibration with shadow factors.
//          Define GAIN_OFFSET_SAT_EN to clamp to signed 32 bits and flag o_sat.
// Rev    : 1.0
// ============================================================================
module adc_gain_offset_calc #(
   parameter int ADC_WIDTH = 18,
   parameter int FRAC_BITS = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   adc_gain_offset_calc_if.slave bus,
   input  logic [31:0]           i_gain_c,
   input  logic [31:0]           i_gain_v,
   input  logic [31:0]           i_gain_dc_c,
   input  logic [31:0]           i_gain_dc_v,
   input  logic [31:0]           i_gain_r,
   input  logic [31:0]           i_gain_s,
   input  logic [31:0]           i_gain_t,
   input  logic [31:0]           i_offset_c,
   input  logic [31:0]           i_offset_v,
   input  logic [31:0]           i_offset_dc_c,
   input  logic [31:0]           i_offset_dc_v,
   input  logic [31:0]           i_offset_r,
   input  logic [31:0]           i_offset_s,
   input  logic [31:0]           i_offset_t,
   input  logic                  i_factor_load,
   input  logic                  i_clr_flags,
   output logic                  o_bad_ch,
   output logic                  o_sat
);
   localparam int         c_PROD_W = ADC_WIDTH + 32;
   localparam int         c_SUM_W  = c_PROD_W + 1;
   localparam logic [2:0] c_CH_BAD = 3'd7;

   logic [31:0] w_live_gain [0:7];
   logic [31:0] w_live_off  [0:7];
   logic [31:0] r_gain_sh   [0:7];
   logic [31:0] r_off_sh    [0:7];

   // Slot 7 is the invalid channel; it always holds zero factors.
   assign w_live_gain[0] = i_gain_c;    assign w_live_off[0] = i_offset_c;
   assign w_live_gain[1] = i_gain_v;    assign w_live_off[1] = i_offset_v;
   assign w_live_gain[2] = i_gain_dc_c; assign w_live_off[2] = i_offset_dc_c;
   assign w_live_gain[3] = i_gain_dc_v; assign w_live_off[3] = i_offset_dc_v;
   assign w_live_gain[4] = i_gain_r;    assign w_live_off[4] = i_offset_r;
   assign w_live_gain[5] = i_gain_s;    assign w_live_off[5] = i_offset_s;
   assign w_live_gain[6] = i_gain_t;    assign w_live_off[6] = i_offset_t;
   assign w_live_gain[7] = '0;          assign w_live_off[7] = '0;

   logic w_advance;
   logic w_accept;
   assign w_advance   = ~bus.o_valid | bus.i_ready;
   assign w_accept    = bus.i_valid & w_advance;
   assign bus.o_ready = w_advance;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < 8; k++) begin
            r_gain_sh[k] <= '0;
            r_off_sh[k]  <= '0;
         end
      end else if (i_factor_load) begin
         for (int k = 0; k < 8; k++) begin
            r_gain_sh[k] <= w_live_gain[k];
            r_off_sh[k]  <= w_live_off[k];
         end
      end
   end

   // Stage 1: capture sample and its shadow factors (pre-load values on a
   // coincident i_factor_load, since the shadow update lands on the same edge).
   logic                 r_s1_valid;
   logic [ADC_WIDTH-1:0] r_s1_data;
   logic [2:0]           r_s1_ch;
   logic [31:0]          r_s1_gain;
   logic [31:0]          r_s1_off;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
         r_s1_ch    <= '0;
         r_s1_gain  <= '0;
         r_s1_off   <= '0;
      end else if (w_advance) begin
         r_s1_valid <= w_accept & (bus.i_ch != c_CH_BAD);
         r_s1_data  <= bus.i_data;
         r_s1_ch    <= bus.i_ch;
         r_s1_gain  <= r_gain_sh[bus.i_ch];
         r_s1_off   <= r_off_sh[bus.i_ch];
      end
   end

   logic signed [c_PROD_W-1:0] w_prod;
   assign w_prod = $signed({{32{r_s1_data[ADC_WIDTH-1]}}, r_s1_data})
                 * $signed({{ADC_WIDTH{r_s1_gain[31]}}, r_s1_gain});

   logic                       r_s2_valid;
   logic signed [c_PROD_W-1:0] r_s2_prod;
   logic [2:0]                 r_s2_ch;
   logic [31:0]                r_s2_off;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s2_valid <= 1'b0;
         r_s2_prod  <= '0;
         r_s2_ch    <= '0;
         r_s2_off   <= '0;
      end else if (w_advance) begin
         r_s2_valid <= r_s1_valid;
         r_s2_prod  <= w_prod;
         r_s2_ch    <= r_s1_ch;
         r_s2_off   <= r_s1_off;
      end
   end

   // Arithmetic shift floors toward minus infinity; one guard bit for the add.
   logic signed [c_PROD_W-1:0] w_shift;
   logic [c_SUM_W-1:0]         w_sum;
   logic [31:0]                w_result;
   assign w_shift = r_s2_prod >>> FRAC_BITS;
   assign w_sum   = {w_shift[c_PROD_W-1], w_shift}
                  + {{(c_SUM_W-32){r_s2_off[31]}}, r_s2_off};

`ifdef GAIN_OFFSET_SAT_EN
   logic w_ovf;
   assign w_ovf    = ~((&w_sum[c_SUM_W-1:31]) | ~(|w_sum[c_SUM_W-1:31]));
   assign w_result = w_ovf ? (w_sum[c_SUM_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                           : w_sum[31:0];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         o_sat <= 1'b0;
      else if (w_advance & r_s2_valid & w_ovf)
         o_sat <= 1'b1;
      else if (i_clr_flags)
         o_sat <= 1'b0;
   end
`else
   logic w_unused_hi;
   assign w_unused_hi = ^w_sum[c_SUM_W-1:32];
   assign w_result    = w_sum[31:0];
   assign o_sat       = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         bus.o_valid <= 1'b0;
         bus.o_data  <= '0;
         bus.o_ch    <= '0;
      end else if (w_advance) begin
         bus.o_valid <= r_s2_valid;
         bus.o_data  <= w_result;
         bus.o_ch    <= r_s2_ch;
      end
   end

   // Setting wins over a coincident clear.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         o_bad_ch <= 1'b0;
      else if (w_accept & (bus.i_ch == c_CH_BAD))
         o_bad_ch <= 1'b1;
      else if (i_clr_flags)
         o_bad_ch <= 1'b0;
   end
endmodule
`default_nettype wire

// File: tb/tb_adc_gain_offset_calc.sv
`default_nettype none
// ============================================================================
// Module : tb_adc_gain_offset_calc
// Brief  : Directed and randomized bench for adc_gain_offset_calc.
// Rev    : 1.0
// ============================================================================
module tb_adc_gain_offset_calc;
   localparam int c_AW   = 18;
   localparam int c_FRAC = 16;

   typedef struct packed {
      logic [31:0] data;
      logic [2:0]  ch;
      logic        sat;
   } exp_t;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        factor_load = 1'b0;
   logic        clr_flags = 1'b0;
   logic        bad_ch;
   logic        sat;
   logic [31:0] live_gain [0:6];
   logic [31:0] live_off  [0:6];

   logic [31:0] sh_gain [0:6];
   logic [31:0] sh_off  [0:6];
   exp_t        exp_q [$];
   logic        exp_bad = 1'b0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_data;
   logic [2:0]  prev_ch;
   int          n_checks = 0;
   int          n_errors = 0;
   int          n_out = 0;

   adc_gain_offset_calc_if #(.ADC_WIDTH(c_AW)) bus ();

   adc_gain_offset_calc #(.ADC_WIDTH(c_AW), .FRAC_BITS(c_FRAC)) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .bus           (bus),
      .i_gain_c      (live_gain[0]),
      .i_gain_v      (live_gain[1]),
      .i_gain_dc_c   (live_gain[2]),
      .i_gain_dc_v   (live_gain[3]),
      .i_gain_r      (live_gain[4]),
      .i_gain_s      (live_gain[5]),
      .i_gain_t      (live_gain[6]),
      .i_offset_c    (live_off[0]),
      .i_offset_v    (live_off[1]),
      .i_offset_dc_c (live_off[2]),
      .i_offset_dc_v (live_off[3]),
      .i_offset_r    (live_off[4]),
      .i_offset_s    (live_off[5]),
      .i_offset_t    (live_off[6]),
      .i_factor_load (factor_load),
      .i_clr_flags   (clr_flags),
      .o_bad_ch      (bad_ch),
      .o_sat         (sat)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Reference: floor(sample * gain / 2^FRAC) + offset, then size to 32 bits.
   function automatic exp_t model(input logic [c_AW-1:0] d, input int ch);
      exp_t   e;
      longint p, q, r;
      p = longint'($signed(d)) * longint'($signed(sh_gain[ch]));
      q = p / (longint'(1) << c_FRAC);
      if ((p % (longint'(1) << c_FRAC) != 0) && (p < 0))
         q = q - 1;
      r = q + longint'($signed(sh_off[ch]));
      e.ch  = 3'(ch);
      e.sat = 1'b0;
      e.data = r[31:0];
`ifdef GAIN_OFFSET_SAT_EN
      if (r > longint'(32'sh7FFF_FFFF)) begin
         e.data = 32'h7FFF_FFFF;
         e.sat  = 1'b1;
      end else if (r < longint'(32'sh8000_0000)) begin
         e.data = 32'h8000_0000;
         e.sat  = 1'b1;
      end
`endif
      return e;
   endfunction

   always @(negedge i_clk) begin
      exp_t e;
      if (i_rst) begin
         exp_q.delete();
         exp_bad    = 1'b0;
         prev_stall = 1'b0;
         for (int k = 0; k < 7; k++) begin
            sh_gain[k] = '0;
            sh_off[k]  = '0;
         end
      end else begin
         check("o_ready_rule", bus.o_ready, !bus.o_valid || bus.i_ready);
         if (prev_stall) begin
            check("stall_valid", bus.o_valid, 1);
            check("stall_data", bus.o_data, prev_data);
            check("stall_ch", bus.o_ch, prev_ch);
         end
         if (bus.o_valid && bus.i_ready) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", bus.o_valid, 0);
            end else begin
               e = exp_q.pop_front();
               check("o_data", bus.o_data, e.data);
               check("o_ch", bus.o_ch, e.ch);
`ifdef GAIN_OFFSET_SAT_EN
               if (e.sat) check("o_sat_set", sat, 1);
`else
               check("o_sat_zero", sat, 0);
`endif
            end
            n_out++;
         end
         check("o_bad_ch", bad_ch, exp_bad);
         if (bus.i_valid && bus.o_ready && bus.i_ch == 3'd7)
            exp_bad = 1'b1;
         else if (clr_flags)
            exp_bad = 1'b0;
         if (bus.i_valid && bus.o_ready && bus.i_ch != 3'd7)
            exp_q.push_back(model(bus.i_data, int'(bus.i_ch)));
         if (factor_load) begin
            for (int k = 0; k < 7; k++) begin
               sh_gain[k] = live_gain[k];
               sh_off[k]  = live_off[k];
            end
         end
         prev_stall = bus.o_valid && !bus.i_ready;
         prev_data  = bus.o_data;
         prev_ch    = bus.o_ch;
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send(input logic [c_AW-1:0] d, input logic [2:0] ch);
      int g = 0;
      bus.i_data  = d;
      bus.i_ch    = ch;
      bus.i_valid = 1'b1;
      @(negedge i_clk);
      while (!bus.o_ready && g < 100) begin
         @(negedge i_clk);
         g++;
      end
      if (!bus.o_ready) check("send_timeout", bus.o_ready, 1);
      tick();
      bus.i_valid = 1'b0;
   endtask

   task automatic wait_out(input string tag, output logic [31:0] d);
      int g = 0;
      @(negedge i_clk);
      while (!bus.o_valid && g < 20) begin
         @(negedge i_clk);
         g++;
      end
      if (!bus.o_valid) check({tag, "_timeout"}, bus.o_valid, 1);
      d = bus.o_data;
      tick();
   endtask

   task automatic drain();
      int g = 0;
      while ((exp_q.size() != 0 || bus.o_valid) && g < 100) begin
         tick();
         g++;
      end
      if (g >= 100) check("drain_timeout", 64'(exp_q.size()), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      int          n0;
      for (int k = 0; k < 7; k++) begin
         live_gain[k] = 32'h0001_0000;
         live_off[k]  = 32'd7;
      end
      bus.i_data  = '0;
      bus.i_ch    = '0;
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      repeat (3) tick();
      check("rst_o_valid", bus.o_valid, 0);
      check("rst_o_ready", bus.o_ready, 1);
      check("rst_o_data", bus.o_data, 0);
      check("rst_bad_ch", bad_ch, 0);
      check("rst_sat", sat, 0);
      i_rst = 1'b0;
      tick();

      // Shadows are still zero: result is the zero offset.
      send(18'd12345, 3'd0);
      wait_out("first", d);
      check("first_after_rst", d, 0);
      drain();

      live_gain[0] = 32'h0001_0000; live_off[0] = 32'hFFFF_FFFB;
      live_gain[1] = 32'h0000_8000; live_off[1] = 32'h0;
      live_gain[4] = 32'h7FFF_FFFF; live_off[4] = 32'h7FFF_FFFF;
      factor_load = 1'b1;
      tick();
      factor_load = 1'b0;

      bus.i_data  = 18'd1000;
      bus.i_ch    = 3'd0;
      bus.i_valid = 1'b1;
      tick();
      bus.i_valid = 1'b0;
      check("lat_edge1", bus.o_valid, 0);
      tick();
      check("lat_edge2", bus.o_valid, 0);
      tick();
      check("lat_edge3", bus.o_valid, 1);
      check("lat_data", bus.o_data, 995);
      check("lat_ch", bus.o_ch, 0);
      drain();

      send(-18'sd3, 3'd1);
      wait_out("neg", d);
      check("neg_floor", d, 32'hFFFF_FFFE);
      drain();

      send(18'd131071, 3'd4);
      wait_out("big", d);
`ifdef GAIN_OFFSET_SAT_EN
      check("big_clamp", d, 32'h7FFF_FFFF);
      check("big_sat", sat, 1);
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
`else
      check("big_wrap", d, 32'h7FFF_7FFD);
      check("big_nosat", sat, 0);
`endif
      drain();

      n0 = n_out;
      fork
         begin
            for (int k = 0; k < 6; k++) send(18'($urandom), 3'(k));
         end
         begin
            repeat (3) tick();
            bus.i_ready = 1'b0;
            repeat (5) tick();
            check("stall_o_ready", bus.o_ready, 0);
            bus.i_ready = 1'b1;
         end
      join
      drain();
      check("stream_count", 64'(n_out - n0), 6);

      n0 = n_out;
      send(18'd500, 3'd2);
      send(18'd600, 3'd7);
      send(18'd700, 3'd3);
      drain();
      check("badch_count", 64'(n_out - n0), 2);
      check("badch_sticky", bad_ch, 1);
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      check("badch_clr", bad_ch, 0);
      clr_flags = 1'b1;
      send(18'd1, 3'd7);
      clr_flags = 1'b0;
      check("badch_set_wins", bad_ch, 1);
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;

      send(18'd10, 3'd0);
      send(18'd20, 3'd1);
      send(18'd30, 3'd0);
      #2;
      i_rst = 1'b1;
      #1;
      check("async_rst_valid", bus.o_valid, 0);
      check("async_rst_ready", bus.o_ready, 1);
      check("async_rst_data", bus.o_data, 0);
      tick();
      tick();
      i_rst = 1'b0;
      repeat (5) tick();
      check("no_stale", bus.o_valid, 0);
      send(18'd777, 3'd0);
      wait_out("post_rst", d);
      check("shadow_zero", d, 0);
      drain();

      for (int i = 0; i < 400; i++) begin
         bus.i_valid = ($urandom_range(0, 3) != 0);
         bus.i_data  = 18'($urandom);
         bus.i_ch    = 3'($urandom_range(0, 7));
         bus.i_ready = ($urandom_range(0, 3) != 0);
         factor_load = ($urandom_range(0, 7) == 0);
         clr_flags   = ($urandom_range(0, 15) == 0);
         for (int k = 0; k < 7; k++) begin
            live_gain[k] = $urandom;
            live_off[k]  = $urandom;
         end
         tick();
      end
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      factor_load = 1'b0;
      clr_flags   = 1'b0;
      drain();
      check("final_empty", 64'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/adc_gain_offset_calc.md
ADC_GAIN_OFFSET_CALC -- requirements
Module: adc_gain_offset_calc

Interface
REQ-001 Parameter ADC_WIDTH, default 18, sets the raw signed ADC sample width.
REQ-002 Parameter FRAC_BITS, default 16, sets the gain fraction bits (gain is signed Q(31-FRAC_BITS).FRAC_BITS).
REQ-003 i_clk  input  1  block clock; one clock, shared with the factor register block.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_data  input  ADC_WIDTH  raw signed sample.
REQ-006 i_ch  input  3  channel: 0 c, 1 v, 2 dc_c, 3 dc_v, 4 phase_r, 5 phase_s, 6 phase_t, 7 invalid.
REQ-007 i_valid  input  1  sample valid; o_ready  output  1  block accepts sample.
REQ-008 i_gain_{c,v,dc_c,dc_v,r,s,t}  input  32 each  live gain factors from the factor register block.
REQ-009 i_offset_{c,v,dc_c,dc_v,r,s,t}  input  32 each  live signed offsets.
REQ-010 i_factor_load  input  1  one-cycle strobe that copies all 14 live factors into shadow registers.
REQ-011 o_data  output  32  calibrated signed result; o_ch  output  3  channel of o_data.
REQ-012 o_valid  output  1  result valid; i_ready  input  1  downstream accepts result.
REQ-013 i_clr_flags  input  1  clears sticky flags; o_bad_ch, o_sat  output  1 each  sticky flags.

Function
REQ-014 Arithmetic SHALL use only shadow factors, never the live inputs directly.
REQ-015 A sample SHALL be accepted on a rising edge with i_valid=1 and o_ready=1.
REQ-016 Pipeline of 3 stages: S1 registers sample, channel, selected shadow gain/offset; S2 registers full-width signed product (ADC_WIDTH+32 bits); S3 registers result.
REQ-017 Latency SHALL be exactly 3 cycles from acceptance to o_valid=1 when not stalled; throughput one sample per cycle.
REQ-018 advance = ~o_valid | i_ready; o_ready SHALL equal advance; when advance=0 all stages SHALL hold contents.
REQ-019 o_data/o_ch SHALL stay stable while o_valid=1 and i_ready=0.
REQ-020 Result = (product >>> FRAC_BITS, arithmetic, rounding toward minus infinity) + sign-extended offset, computed at full width before output sizing.
REQ-021 Sample with i_ch=7 SHALL be accepted, dropped (no o_valid), and SHALL set o_bad_ch.
REQ-022 i_factor_load coincident with acceptance: that sample SHALL use the old shadow values; following samples use the new ones.
REQ-023 i_clr_flags coincident with a flag-setting event: the set SHALL win.
REQ-024 Samples SHALL leave in acceptance order; no sample lost or duplicated under any i_ready pattern.

Reset
REQ-025 On i_rst=1 all stage valids, o_valid, o_data, o_ch, o_bad_ch, o_sat and all shadow registers SHALL go to 0 immediately, independent of i_clk.
REQ-026 o_ready SHALL be 1 during and after reset; in-flight samples at reset SHALL be discarded.
REQ-027 First sample after reset SHALL produce o_data=offset-only result of 0 until i_factor_load is pulsed.

Configuration
REQ-028 Macro GAIN_OFFSET_SAT_EN defined: result outside signed 32-bit range SHALL clamp to 0x7FFFFFFF / 0x80000000 and set o_sat.
REQ-029 Macro GAIN_OFFSET_SAT_EN undefined: o_data SHALL be the low 32 bits (two's-complement wrap) and o_sat SHALL be tied 0.

Verification
REQ-030 Load gain_c=0x00010000, offset_c=0xFFFFFFFB; sample 1000 ch0 -> o_data=995, o_ch=0, o_valid exactly 3 cycles after acceptance.
REQ-031 gain_v=0x00008000, offset 0; sample -3 ch1 -> o_data=0xFFFFFFFE (-2).
REQ-032 SAT_EN defined, gain_r=0x7FFFFFFF, offset_r=0x7FFFFFFF, sample 131071 ch4 -> o_data=0x7FFFFFFF, o_sat=1; undefined -> wrapped low 32 bits, o_sat=0.
REQ-033 Send 6 back-to-back samples, hold i_ready=0 for 5 cycles mid-stream -> o_ready drops, all 6 results out in order, o_data stable while stalled.
REQ-034 Sample ch7 between two valid samples -> only 2 results, o_bad_ch=1 until i_clr_flags pulse.
REQ-035 Assert i_rst with 3 samples in flight -> o_valid=0 at once, no stale result emitted after release, shadows read 0.
